// File: rtl/riscv_pkg.sv
`default_nettype none
// ============================================================================
// Module   : riscv_pkg
// Purpose  : Shared core-wide constants and types. Holds XLEN and the retire
//            trace record that retire_trace_fifo buffers between the core's
//            retire port and a trace consumer.
// Contents : XLEN, TRACE_SEQ_W, retire_pkt_t
// Revision : 1.0 - retire trace record and sequence width added
// ============================================================================
package riscv_pkg;

   localparam int XLEN        = 32;
   localparam int TRACE_SEQ_W = 32;

   // One retired instruction. seq is stamped by the trace buffer, not the
   // core, so a gap at the consumer exposes records lost to overflow.
   typedef struct packed {
      logic [TRACE_SEQ_W-1:0] seq;
      logic [XLEN-1:0]        pc;
      logic [XLEN-1:0]        instr;
      logic [4:0]             reg_addr;
      logic [XLEN-1:0]        reg_data;
      logic [XLEN-1:0]        mem_addr;
      logic [XLEN-1:0]        mem_data;
      logic                   mem_wrt;
   } retire_pkt_t;

endpackage : riscv_pkg
`default_nettype wire

// File: rtl/sync_fifo.sv
`default_nettype none
// ============================================================================
// Module   : sync_fifo
// Purpose  : Generic single-clock flop-based FIFO. Head data is read
//            combinationally from the array (no bypass: a push into an empty
//            FIFO becomes visible the following cycle).
// Ports    : clk, reset      - clock, asynchronous active-high reset
//            i_flush         - synchronous clear; overrides push and pop
//            i_push, i_data  - write request and data (ignored when full
//                              unless a pop happens in the same cycle)
//            i_pop           - read request (ignored when empty)
//            o_data          - head entry
//            o_full, o_empty - status
//            o_count         - occupancy (0..DEPTH)
//            o_count_nxt     - occupancy after the coming clock edge
// Revision : 1.0 - initial release
// ============================================================================
module sync_fifo #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 16,
   localparam int AW   = $clog2(DEPTH)
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             i_flush,
   input  logic             i_push,
   input  logic [WIDTH-1:0] i_data,
   input  logic             i_pop,
   output logic [WIDTH-1:0] o_data,
   output logic             o_full,
   output logic             o_empty,
   output logic [AW:0]      o_count,
   output logic [AW:0]      o_count_nxt
);

   logic [WIDTH-1:0] r_mem [DEPTH];
   logic [AW-1:0]    r_wr_ptr;
   logic [AW-1:0]    r_rd_ptr;
   logic [AW:0]      r_count;
   logic             w_pop;
   logic             w_push;

   assign o_full  = (r_count == (AW+1)'(DEPTH));
   assign o_empty = (r_count == '0);
   assign o_count = r_count;
   assign o_data  = r_mem[r_rd_ptr];

   // A pop frees the slot the push needs, so a full FIFO can still accept
   // a write in the same cycle it is read.
   assign w_pop  = i_pop & ~o_empty & ~i_flush;
   assign w_push = i_push & (~o_full | w_pop) & ~i_flush;

   always_comb begin
      o_count_nxt = r_count;
      if (i_flush)
         o_count_nxt = '0;
      else if (w_push & ~w_pop)
         o_count_nxt = r_count + (AW+1)'(1);
      else if (w_pop & ~w_push)
         o_count_nxt = r_count - (AW+1)'(1);
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else begin
         r_count <= o_count_nxt;
         if (i_flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
         end else begin
            // Pointers are exactly log2(DEPTH) wide and wrap on overflow.
            if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
            if (w_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
         end
      end
   end

   // Storage needs no reset: entries are only observed while counted valid.
   always_ff @(posedge clk) begin
      if (w_push) r_mem[r_wr_ptr] <= i_data;
   end

endmodule : sync_fifo
`default_nettype wire

// File: rtl/retire_trace_fifo.sv
`default_nettype none
// ============================================================================
// Module   : retire_trace_fifo
// Purpose  : Buffers retire records from the core and drains them to a trace
//            consumer over valid/ready. Stamps each retire with a sequence
//            number (advanced even for lost records) and tracks losses with
//            a saturating drop counter and a sticky overflow flag.
// Ports    : clk, reset             - clock, asynchronous active-high reset
//            update_i + *_i fields  - retire record from the core
//            flush_i                - synchronous FIFO clear
//            clr_stat_i             - clear drop_cnt_o / overflow_o
//            trace_valid_o/ready_i  - consumer handshake
//            trace_o                - head record, zero when not valid
//            stall_o                - almost-full (count >= DEPTH-2)
//            count_o                - occupancy
//            drop_cnt_o, overflow_o - loss statistics
// Revision : 1.0 - initial release
// ============================================================================
module retire_trace_fifo
   import riscv_pkg::*;
#(
   parameter int DEPTH = 16,
   parameter int CNT_W = 16
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     update_i,
   input  logic [XLEN-1:0]          pc_i,
   input  logic [XLEN-1:0]          instr_i,
   input  logic [4:0]               reg_addr_i,
   input  logic [XLEN-1:0]          reg_data_i,
   input  logic [XLEN-1:0]          mem_addr_i,
   input  logic [XLEN-1:0]          mem_data_i,
   input  logic                     mem_wrt_i,
   input  logic                     flush_i,
   input  logic                     clr_stat_i,
   output logic                     trace_valid_o,
   input  logic                     trace_ready_i,
   output retire_pkt_t              trace_o,
   output logic                     stall_o,
   output logic [$clog2(DEPTH):0]   count_o,
   output logic [CNT_W-1:0]         drop_cnt_o,
   output logic                     overflow_o
);

   localparam int AW = $clog2(DEPTH);

   logic [TRACE_SEQ_W-1:0] r_seq;
   logic [CNT_W-1:0]       r_drop_cnt;
   logic                   r_overflow;
   logic                   r_stall;
   retire_pkt_t            w_pkt;
   retire_pkt_t            w_head;
   logic                   w_full;
   logic                   w_empty;
   logic [AW:0]            w_count;
   logic [AW:0]            w_count_nxt;
   logic                   w_pop;
   logic                   w_drop;

   assign w_pkt = '{seq:      r_seq,
                    pc:       pc_i,
                    instr:    instr_i,
                    reg_addr: reg_addr_i,
                    reg_data: reg_data_i,
                    mem_addr: mem_addr_i,
                    mem_data: mem_data_i,
                    mem_wrt:  mem_wrt_i};

   sync_fifo #(
      .WIDTH ($bits(retire_pkt_t)),
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk         (clk),
      .reset       (reset),
      .i_flush     (flush_i),
      .i_push      (update_i),
      .i_data      (w_pkt),
      .i_pop       (trace_ready_i),
      .o_data      (w_head),
      .o_full      (w_full),
      .o_empty     (w_empty),
      .o_count     (w_count),
      .o_count_nxt (w_count_nxt)
   );

   assign trace_valid_o = ~w_empty;
   assign trace_o       = trace_valid_o ? w_head : '0;
   assign w_pop         = trace_valid_o & trace_ready_i;

   // A flush discards the FIFO deliberately; that is not counted as loss.
   assign w_drop = update_i & w_full & ~w_pop & ~flush_i;

   assign count_o    = w_count;
   assign stall_o    = r_stall;
   assign drop_cnt_o = r_drop_cnt;
   assign overflow_o = r_overflow;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_seq      <= '0;
         r_drop_cnt <= '0;
         r_overflow <= 1'b0;
         r_stall    <= 1'b0;
      end else begin
         // Every retire consumes a sequence number, pushed or not.
         if (update_i) r_seq <= r_seq + TRACE_SEQ_W'(1);

         r_stall <= (w_count_nxt >= (AW+1)'(DEPTH-2));

         // A drop in the same cycle as a clear survives as the first event.
         if (clr_stat_i) begin
            r_drop_cnt <= w_drop ? CNT_W'(1) : '0;
            r_overflow <= w_drop;
         end else if (w_drop) begin
            if (r_drop_cnt != '1) r_drop_cnt <= r_drop_cnt + CNT_W'(1);
            r_overflow <= 1'b1;
         end
      end
   end

endmodule : retire_trace_fifo
`default_nettype wire

// File: tb/tb_retire_trace_fifo.sv
`default_nettype none
// ============================================================================
// Module   : tb_retire_trace_fifo
// Purpose  : Directed self-checking bench for retire_trace_fifo. The drop
//            counter is instantiated narrow (4 bits) so saturation at
//            all-ones is reached in a few cycles.
// Revision : 1.0 - initial release
// ============================================================================
module tb_retire_trace_fifo;
   import riscv_pkg::*;

   localparam int DEPTH = 16;
   localparam int CNT_W = 4;

   logic              clk;
   logic              reset;
   logic              update_i;
   logic [XLEN-1:0]   pc_i;
   logic [XLEN-1:0]   instr_i;
   logic [4:0]        reg_addr_i;
   logic [XLEN-1:0]   reg_data_i;
   logic [XLEN-1:0]   mem_addr_i;
   logic [XLEN-1:0]   mem_data_i;
   logic              mem_wrt_i;
   logic              flush_i;
   logic              clr_stat_i;
   logic              trace_valid_o;
   logic              trace_ready_i;
   retire_pkt_t       trace_o;
   logic              stall_o;
   logic [4:0]        count_o;
   logic [CNT_W-1:0]  drop_cnt_o;
   logic              overflow_o;

   int errors = 0;
   int checks = 0;

   retire_trace_fifo #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
      .clk           (clk),
      .reset         (reset),
      .update_i      (update_i),
      .pc_i          (pc_i),
      .instr_i       (instr_i),
      .reg_addr_i    (reg_addr_i),
      .reg_data_i    (reg_data_i),
      .mem_addr_i    (mem_addr_i),
      .mem_data_i    (mem_data_i),
      .mem_wrt_i     (mem_wrt_i),
      .flush_i       (flush_i),
      .clr_stat_i    (clr_stat_i),
      .trace_valid_o (trace_valid_o),
      .trace_ready_i (trace_ready_i),
      .trace_o       (trace_o),
      .stall_o       (stall_o),
      .count_o       (count_o),
      .drop_cnt_o    (drop_cnt_o),
      .overflow_o    (overflow_o)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #100000;
      $display("FAIL watchdog: observed=timeout expected=finish");
      $fatal(1, "watchdog expired");
   end

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic set_in(input logic upd, input logic rdy, input logic [31:0] pc);
      update_i      = upd;
      trace_ready_i = rdy;
      pc_i          = pc;
      instr_i       = ~pc;
      reg_addr_i    = pc[6:2];
      reg_data_i    = pc + 32'h100;
      mem_addr_i    = pc + 32'h200;
      mem_data_i    = pc + 32'h300;
      mem_wrt_i     = pc[2];
   endtask

   // Outputs are sampled 1 time unit after the active edge.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic rst_pulse();
      set_in(1'b0, 1'b0, 32'h0);
      reset = 1'b1;
      #2;
      reset = 1'b0;
   endtask

   task automatic chk_all_zero(input string tag);
      chk({tag, "_valid"}, 64'(trace_valid_o), 64'd0);
      chk({tag, "_trace"}, 64'(|trace_o), 64'd0);
      chk({tag, "_stall"}, 64'(stall_o), 64'd0);
      chk({tag, "_count"}, 64'(count_o), 64'd0);
      chk({tag, "_drop"},  64'(drop_cnt_o), 64'd0);
      chk({tag, "_ovf"},   64'(overflow_o), 64'd0);
   endtask

   initial begin
      int exp_cnt;
      reset      = 1'b1;
      flush_i    = 1'b0;
      clr_stat_i = 1'b0;
      set_in(1'b0, 1'b0, 32'h0);
      #3;
      chk_all_zero("reset");
      tick();
      reset = 1'b0;

      // --- three back-to-back retires, consumer always ready
      set_in(1'b1, 1'b1, 32'h0);
      tick();
      chk("t1_valid0", 64'(trace_valid_o), 64'd1);
      chk("t1_seq0",   64'(trace_o.seq), 64'd0);
      chk("t1_pc0",    64'(trace_o.pc), 64'h0);
      chk("t1_instr0", 64'(trace_o.instr), 64'hFFFF_FFFF);
      chk("t1_cnt0",   64'(count_o), 64'd1);
      set_in(1'b1, 1'b1, 32'h4);
      tick();
      chk("t1_seq1",   64'(trace_o.seq), 64'd1);
      chk("t1_pc1",    64'(trace_o.pc), 64'h4);
      chk("t1_mdata1", 64'(trace_o.mem_data), 64'h304);
      chk("t1_cnt1",   64'(count_o), 64'd1);
      set_in(1'b1, 1'b1, 32'h8);
      tick();
      chk("t1_seq2",   64'(trace_o.seq), 64'd2);
      chk("t1_pc2",    64'(trace_o.pc), 64'h8);
      chk("t1_cnt2",   64'(count_o), 64'd1);
      set_in(1'b0, 1'b1, 32'h0);
      tick();
      chk("t1_empty_valid", 64'(trace_valid_o), 64'd0);
      chk("t1_empty_trace", 64'(|trace_o), 64'd0);
      chk("t1_empty_cnt",   64'(count_o), 64'd0);

      // --- consumer stalled, DEPTH+2 retires: fill, stall, two drops
      rst_pulse();
      for (int i = 0; i < DEPTH + 2; i++) begin
         set_in(1'b1, 1'b0, 32'(i * 4));
         tick();
         exp_cnt = (i + 1 > DEPTH) ? DEPTH : i + 1;
         chk("t2_cnt",   64'(count_o), 64'(exp_cnt));
         chk("t2_stall", 64'(stall_o), 64'(exp_cnt >= DEPTH - 2));
         chk("t2_head",  64'(trace_o.seq), 64'd0);
      end
      chk("t2_drop", 64'(drop_cnt_o), 64'd2);
      chk("t2_ovf",  64'(overflow_o), 64'd1);
      set_in(1'b0, 1'b1, 32'h0);
      for (int k = 0; k < DEPTH; k++) begin
         chk("t2_dvalid", 64'(trace_valid_o), 64'd1);
         chk("t2_dseq",   64'(trace_o.seq), 64'(k));
         chk("t2_dpc",    64'(trace_o.pc), 64'(k * 4));
         tick();
      end
      chk("t2_end_valid", 64'(trace_valid_o), 64'd0);
      chk("t2_end_cnt",   64'(count_o), 64'd0);
      chk("t2_end_stall", 64'(stall_o), 64'd0);
      chk("t2_end_ovf",   64'(overflow_o), 64'd1);

      // --- full FIFO, simultaneous push and pop: no loss
      rst_pulse();
      for (int i = 0; i < DEPTH; i++) begin
         set_in(1'b1, 1'b0, 32'(i * 4));
         tick();
      end
      chk("t3_full", 64'(count_o), 64'(DEPTH));
      for (int k = 0; k < 10; k++) begin
         set_in(1'b1, 1'b1, 32'((DEPTH + k) * 4));
         chk("t3_seq", 64'(trace_o.seq), 64'(k));
         tick();
         chk("t3_cnt", 64'(count_o), 64'(DEPTH));
      end
      chk("t3_drop", 64'(drop_cnt_o), 64'd0);
      chk("t3_ovf",  64'(overflow_o), 64'd0);
      set_in(1'b0, 1'b1, 32'h0);
      for (int k = 10; k < 10 + DEPTH; k++) begin
         chk("t3_dseq", 64'(trace_o.seq), 64'(k));
         tick();
      end
      chk("t3_end_cnt", 64'(count_o), 64'd0);

      // --- drop counter saturation and clear-versus-drop priority
      rst_pulse();
      for (int i = 0; i < DEPTH + 15; i++) begin
         set_in(1'b1, 1'b0, 32'(i * 4));
         tick();
      end
      chk("t4_drop15", 64'(drop_cnt_o), 64'hF);
      tick();
      chk("t4_sat",     64'(drop_cnt_o), 64'hF);
      chk("t4_sat_ovf", 64'(overflow_o), 64'd1);
      clr_stat_i = 1'b1;
      tick();
      chk("t4_clr_drop", 64'(drop_cnt_o), 64'd1);
      chk("t4_clr_ovf",  64'(overflow_o), 64'd1);
      set_in(1'b0, 1'b0, 32'h0);
      tick();
      chk("t4_clr2_drop", 64'(drop_cnt_o), 64'd0);
      chk("t4_clr2_ovf",  64'(overflow_o), 64'd0);
      chk("t4_clr2_cnt",  64'(count_o), 64'(DEPTH));
      clr_stat_i = 1'b0;

      // --- flush with a concurrent retire
      rst_pulse();
      for (int i = 0; i < 5; i++) begin
         set_in(1'b1, 1'b0, 32'(i * 4));
         tick();
      end
      chk("t5_cnt5", 64'(count_o), 64'd5);
      flush_i = 1'b1;
      set_in(1'b1, 1'b1, 32'h14);
      tick();
      flush_i = 1'b0;
      chk("t5_fl_cnt",   64'(count_o), 64'd0);
      chk("t5_fl_valid", 64'(trace_valid_o), 64'd0);
      chk("t5_fl_trace", 64'(|trace_o), 64'd0);
      set_in(1'b1, 1'b0, 32'h18);
      tick();
      chk("t5_seq6",   64'(trace_o.seq), 64'd6);
      chk("t5_pc",     64'(trace_o.pc), 64'h18);
      chk("t5_cnt1",   64'(count_o), 64'd1);

      // --- asynchronous reset mid-cycle with 7 entries queued
      rst_pulse();
      for (int i = 0; i < 7; i++) begin
         set_in(1'b1, 1'b0, 32'(i * 4));
         tick();
      end
      chk("t6_cnt7",   64'(count_o), 64'd7);
      chk("t6_valid",  64'(trace_valid_o), 64'd1);
      set_in(1'b0, 1'b0, 32'h0);
      #3;
      reset = 1'b1;
      #1;
      chk_all_zero("t6_rst");
      #1;
      reset = 1'b0;
      set_in(1'b1, 1'b0, 32'h40);
      tick();
      chk("t6_seq0",  64'(trace_o.seq), 64'd0);
      chk("t6_pc",    64'(trace_o.pc), 64'h40);
      chk("t6_cnt1",  64'(count_o), 64'd1);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule : tb_retire_trace_fifo
`default_nettype wire

// File: doc/retire_trace_fifo.md
# retire_trace_fifo

Buffers the per-instruction retire record produced by `riscv_single` (update/pc/instr/reg/mem retire outputs) and drains it to a trace consumer over a valid/ready handshake. It sits directly downstream of the core's retire port and feeds the simulation checker or debug UART. It decouples a consumer that may stall from a core that retires one instruction per cycle. It flags lost records with sequence-number gaps, a saturating drop counter and a sticky overflow bit.

## Interface
- `DEPTH`, 16, FIFO entries; power of two, ≥4
- `CNT_W`, 16, drop-counter width
- `clk` in 1: clock
- `reset` in 1: reset, asynchronous, active-high
- `update_i` in 1: core retired an instruction this cycle
- `pc_i`, `instr_i`, `reg_data_i`, `mem_addr_i`, `mem_data_i` in XLEN each: retire fields
- `reg_addr_i` in 5: retired destination register
- `mem_wrt_i` in 1: retired store
- `flush_i` in 1: synchronous FIFO clear
- `clr_stat_i` in 1: synchronous clear of `drop_cnt_o` and `overflow_o`
- `trace_valid_o` out 1: head record available
- `trace_ready_i` in 1: consumer accepts head
- `trace_o` out `retire_pkt_t`: head record
- `stall_o` out 1: almost-full, for optional core hold
- `count_o` out $clog2(DEPTH)+1: occupancy
- `drop_cnt_o` out CNT_W: records lost, saturating
- `overflow_o` out 1: sticky, set on the first drop

## Operation
- `retire_pkt_t` = {seq[31:0], pc, instr, reg_addr, reg_data, mem_addr, mem_data, mem_wrt}.
- `seq` counter starts at 0 and increments on every `update_i`, including dropped records. The pushed record carries the pre-increment value, so a gap in `seq` at the consumer reveals loss.
- Pop = `trace_valid_o & trace_ready_i`. Push = `update_i & (count<DEPTH | pop)`.
- Drop = `update_i & count==DEPTH & ~pop`.
  - A drop increments `drop_cnt_o` (saturating at all-ones) and sets `overflow_o`.
- Simultaneous push and pop when full: both occur and count is unchanged. The same applies when not full and not empty.
- Empty and push in the same cycle: no bypass. The record appears the next cycle.
- Read/write pointers are log2(DEPTH) bits and wrap naturally. The count is tracked separately (DEPTH+1 states).
- `flush_i` clears the pointers and count, drops any same-cycle push, and discards any same-cycle pop.
  - `seq` still increments if `update_i` is set.
  - `drop_cnt_o` and `overflow_o` are untouched.
- `clr_stat_i` clears `drop_cnt_o` and `overflow_o`.
  - If a drop occurs in the same cycle, the result is `drop_cnt_o`=1 and `overflow_o`=1 (the event wins).
- `stall_o` = count ≥ DEPTH-2, registered from next-count.
- `trace_o` is forced to all-zero when `trace_valid_o`=0.
- The consumer may deassert `trace_ready_i` at any time. `trace_o` is stable while valid is held and not popped.

## Timing
- Reset values: `trace_valid_o`=0, `trace_o`=0, `stall_o`=0, `count_o`=0, `drop_cnt_o`=0, `overflow_o`=0. `seq` and the pointers are 0.
- Push in cycle N → `trace_valid_o`=1 with that record in cycle N+1.
- `count_o`, `stall_o`, `drop_cnt_o` and `overflow_o` update on the clock edge following the event.
- Throughput is one push and one pop per cycle sustained.
- Reset asserted mid-stream discards all contents immediately (asynchronous). The first record after reset carries `seq`=0.
- Storage is flops (no SRAM). The head read is combinational from the array, muxed by the read pointer.

## Structure
- `riscv_pkg` gains `retire_pkt_t` and `TRACE_SEQ_W = 32`. `XLEN` comes from the existing package.
- Sub-module `sync_fifo` is generic and parameterised by width and depth, with push/pop/full/empty/count. It is reusable for a later UART TX path.
- `retire_trace_fifo` contains the seq counter, drop/overflow logic, `stall_o` register and output gating.

## Test plan
- Reset, then 3 consecutive `update_i` with pc 0x0,0x4,0x8 and ready=1 → valid from cycle 2; records out in order with seq 0,1,2; count never exceeds 1.
- ready=0, DEPTH+2 updates → count=16, `stall_o`=1 after the 14th push, 2 drops, `drop_cnt_o`=2, `overflow_o`=1. Draining gives seq 0..15.
- Full FIFO with ready=1 and `update_i`=1 for 10 cycles → zero drops, count stays 16, output seq strictly consecutive.
- `drop_cnt_o` at 0xFFFF plus another drop → stays 0xFFFF. `clr_stat_i` together with a drop → `drop_cnt_o`=1, `overflow_o`=1.
- 5 entries queued, `flush_i` together with `update_i` → count=0, valid=0 next cycle. The next pushed record's seq is 6.
- `reset` asserted mid-clock with 7 entries queued → all outputs 0 immediately. After release, the first record carries seq 0.
